// File: rtl/fanout_pkg.sv
// Shared sizing and storage types for the eager-fork fanout block.
// The stop bit is the MSB of each word and is carried through untouched.
package fanout_pkg;
  localparam int NUM_OUT  = 9;
  localparam int DATA_W   = 17;
  localparam int STOP_BIT = DATA_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [NUM_OUT-1:0] pending;
  } entry_t;
endpackage

// File: rtl/fanout_entry_buf2.sv
// Two-entry in-order store with occupancy count and per-entry pending masks.
// The head's pending bits can be cleared in place while it waits to retire.
module fanout_entry_buf2
  import fanout_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  entry_t             push_entry,
  input  logic               pop,
  input  logic [NUM_OUT-1:0] clr,
  output entry_t             head,
  output logic [1:0]         count
);

  logic [DATA_W-1:0]  dat [2];
  logic [NUM_OUT-1:0] pnd [2];
  logic               rd_ptr;
  logic               wr_ptr;

  assign head = '{data: dat[rd_ptr], pending: pnd[rd_ptr]};

  always_ff @(posedge clk) begin
    if (push) dat[wr_ptr] <= push_entry.data;
  end

  // A push into the slot being popped (full, retire+accept) must win over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      pnd[0] <= '0;
      pnd[1] <= '0;
    end else begin
      if (count != 2'd0) pnd[rd_ptr] <= pnd[rd_ptr] & ~clr;
      if (push) begin
        pnd[wr_ptr] <= push_entry.pending;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fanout_eager_fork.sv
// Eager fork: every active destination takes the head word independently;
// the head retires once its last pending destination has handshaken.
module fanout_eager_fork
  import fanout_pkg::entry_t;
#(
  parameter int NUM_OUT = fanout_pkg::NUM_OUT,
  parameter int DATA_W  = fanout_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_OUT-1:0]        cfg_en,
  input  logic [NUM_OUT-1:0]        cfg_sel,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic                      busy
);

  entry_t             head;
  entry_t             push_entry;
  logic [1:0]         count;
  logic [NUM_OUT-1:0] act;
  logic [NUM_OUT-1:0] hs;
  logic               head_retire;
  logic               accept;

  assign act        = cfg_en & cfg_sel;
  assign push_entry = '{data: in_data, pending: act};

  assign out_valid = (count != 2'd0) ? head.pending : '0;
  assign out_data  = {NUM_OUT{head.data}};
  assign hs        = out_valid & out_ready;

  // A zero-mask head retires on its first cycle as head without any handshake.
  assign head_retire = (count != 2'd0) && ((head.pending & ~hs) == '0);
  assign in_ready    = !rst && ((count < 2'd2) || head_retire);
  assign accept      = in_valid && in_ready;
  assign busy        = (count != 2'd0);

  fanout_entry_buf2 u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (head_retire),
    .clr        (hs),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Directed bench for fanout_eager_fork: per-destination expected-word queues
// are filled by the driver and drained by a monitor on every handshake.
module tb_fanout_eager_fork;
  localparam int N = 9;
  localparam int W = 17;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cfg_en, cfg_sel;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic           busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] expq [N][$];

  fanout_eager_fork dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .cfg_sel   (cfg_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] w, input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i]) expq[i].push_back(w);
  endtask

  // Monitor: every presented word must match the front of that destination's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("mon_unexpected_valid_d%0d", i), {31'd0, out_valid[i]}, 32'd0);
          end else begin
            chk($sformatf("mon_data_d%0d", i), {15'd0, out_data[i*W +: W]}, {15'd0, expq[i][0]});
            if (out_ready[i]) void'(expq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_en = '0; cfg_sel = '0; in_data = '0; in_valid = 1'b0; out_ready = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {23'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // All destinations, back-to-back words
    tick();
    cfg_en = 9'h1FF; cfg_sel = 9'h1FF; out_ready = 9'h1FF;
    for (int k = 1; k <= 4; k++) begin
      in_data = W'(k); in_valid = 1'b1;
      @(negedge clk);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t1_out_valid", {23'd0, out_valid}, (k > 1) ? 32'h1FF : 32'h0);
      push_exp(W'(k), 9'h1FF);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_last_valid", {23'd0, out_valid}, 32'h1FF);
    chk("t1_last_data", {15'd0, out_data[W-1:0]}, 32'h4);
    tick();
    @(negedge clk);
    chk("t1_drained", {23'd0, out_valid}, 32'h0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Two destinations, dest1 ready three cycles late
    tick();
    cfg_en = 9'h1FF; cfg_sel = 9'h003; out_ready = 9'h1FD;
    in_data = 17'h000AA; in_valid = 1'b1;
    @(negedge clk);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    push_exp(17'h000AA, 9'h003);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_ov_t1", {23'd0, out_valid}, 32'h3);
    tick();
    @(negedge clk);
    chk("t2_ov_t2", {23'd0, out_valid}, 32'h2);
    tick();
    @(negedge clk);
    chk("t2_ov_t3", {23'd0, out_valid}, 32'h2);
    tick();
    out_ready = 9'h1FF;
    @(negedge clk);
    chk("t2_ov_t4pre", {23'd0, out_valid}, 32'h2);
    chk("t2_busy_t4pre", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_retired_ov", {23'd0, out_valid}, 32'h0);
    chk("t2_retired_busy", {31'd0, busy}, 32'd0);

    // Backpressure: fill both entries, then pop and accept together
    tick();
    cfg_sel = 9'h1FF; out_ready = 9'h000;
    in_data = 17'h00011; in_valid = 1'b1;
    @(negedge clk);
    chk("t3_acc1", {31'd0, in_ready}, 32'd1);
    push_exp(17'h00011, 9'h1FF);
    tick();
    in_data = 17'h00022;
    @(negedge clk);
    chk("t3_acc2", {31'd0, in_ready}, 32'd1);
    push_exp(17'h00022, 9'h1FF);
    tick();
    in_data = 17'h00033;
    @(negedge clk);
    chk("t3_full_a", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_full_b", {31'd0, in_ready}, 32'd0);
    chk("t3_head_ov", {23'd0, out_valid}, 32'h1FF);
    chk("t3_head_data", {15'd0, out_data[W-1:0]}, 32'h11);
    tick();
    out_ready = 9'h1FF;
    @(negedge clk);
    chk("t3_retire_ready", {31'd0, in_ready}, 32'd1);
    push_exp(17'h00033, 9'h1FF);
    tick();
    in_valid = 1'b0; out_ready = 9'h000;
    @(negedge clk);
    chk("t3_still_full", {31'd0, in_ready}, 32'd0);
    chk("t3_new_head", {15'd0, out_data[W-1:0]}, 32'h22);
    tick();
    out_ready = 9'h1FF;
    tick(); tick();
    @(negedge clk);
    chk("t3_drained", {31'd0, busy}, 32'd0);

    // Zero mask: accepted, never presented, one cycle of occupancy each
    tick();
    cfg_en = 9'h1FF; cfg_sel = 9'h000;
    for (int k = 0; k < 3; k++) begin
      in_data = W'(17'h00100 + k); in_valid = 1'b1;
      @(negedge clk);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_busy_pulse", {31'd0, busy}, 32'd1);
      chk("t4_no_valid", {23'd0, out_valid}, 32'h0);
      tick();
      @(negedge clk);
      chk("t4_busy_clear", {31'd0, busy}, 32'd0);
      tick();
    end

    // Reset with two entries and a partially delivered head
    cfg_sel = 9'h1FF; out_ready = 9'h001;
    in_data = 17'h00055; in_valid = 1'b1;
    push_exp(17'h00055, 9'h1FF);
    tick();
    in_data = 17'h00066;
    push_exp(17'h00066, 9'h1FF);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_partial", {23'd0, out_valid}, 32'h1FE);
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) expq[i].delete();
    @(negedge clk);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0; out_ready = 9'h1FF;
    @(negedge clk);
    chk("t5_ov_cleared", {23'd0, out_valid}, 32'h0);
    chk("t5_busy_cleared", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_no_stale", {23'd0, out_valid}, 32'h0);

    // Stop bit forwarded bit-exact to dest8
    tick();
    cfg_sel = 9'h100;
    in_data = 17'h10005; in_valid = 1'b1;
    @(negedge clk);
    push_exp(17'h10005, 9'h100);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_ov", {23'd0, out_valid}, 32'h100);
    chk("t6_data_d8", {15'd0, out_data[8*W +: W]}, 32'h10005);
    tick(); tick();

    for (int i = 0; i < N; i++)
      chk($sformatf("final_queue_empty_d%0d", i), expq[i].size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
